// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, defaults and decode helper for the 2-to-4 stream decoder
//
// Purpose: common definitions used by decoder_2to4_stream and dec_fifo2.
//   - occ_state_e : buffer occupancy state (EMPTY=0, ONE=1, FULL=2)
//   - DEC_SEL_W / DEC_OUT_W / DEC_ERR_CNT_W : default widths
//   - dec_decode  : (invalid, sel) -> {err, onehot}
// Ports: none (package).

package decoder_pkg;

  localparam int DEC_SEL_W     = 2;
  localparam int DEC_OUT_W     = 1 << DEC_SEL_W;
  localparam int DEC_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // An invalid code decodes to an all-zero word with the error bit set.
  function automatic logic [DEC_OUT_W:0] dec_decode(input logic                 invalid,
                                                    input logic [DEC_SEL_W-1:0] sel);
    logic [DEC_OUT_W-1:0] onehot;
    onehot = '0;
    if (!invalid) begin
      onehot[sel] = 1'b1;
    end
    return {invalid, onehot};
  endfunction

endpackage

// File: rtl/dec_fifo2.sv
// rtl/dec_fifo2.sv - 2-entry buffer with occupancy FSM and registered-only ready
//
// Purpose: holds up to two decoded words; head register drives the output so
//   the presented word is stable while stalled. push_ready_o depends only on
//   the state register (and reset), never on pop_ready_i.
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   push_valid_i word offered for storage
//   push_data_i  word to store
//   push_ready_o buffer can take a word (state != FULL, forced 0 in reset)
//   pop_valid_o  head entry holds a word (state != EMPTY)
//   pop_ready_i  consumer takes the head word
//   pop_data_o   head entry

module dec_fifo2
  import decoder_pkg::*;
#(
  parameter int DATA_W = DEC_OUT_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] pop_data_o
);

  occ_state_e        state_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic              push;
  logic              pop;

  assign push_ready_o = rst_n_i && (state_q != FULL);
  assign pop_valid_o  = (state_q != EMPTY);
  assign pop_data_o   = head_q;

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= push_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head leaves as the new word arrives, so the new word takes its place.
            head_q <= push_data_i;
          end else if (push) begin
            tail_q  <= push_data_i;
            state_q <= FULL;
          end else if (pop) begin
            head_q  <= '0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/decoder_2to4_stream.sv
// rtl/decoder_2to4_stream.sv - valid/ready one-hot decoder with error tally
//
// Purpose: turns {invalid, sel} codes back into one-hot words through a
//   2-entry buffer, and counts accepted invalid codes (saturating).
// Optional feature macro: DECODER_DROP_INVALID_EN - invalid words complete the
//   handshake and are counted but are not stored; err_out is tied 0.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   encoded word present
//   in_ready   block can accept a word (registered state only)
//   invalid_in encoder invalid flag
//   sel_in     encoded select
//   out_valid  decoded word present
//   out_ready  consumer accepts word
//   data_out   one-hot word (zero for invalid)
//   err_out    head word came from an invalid code
//   err_clr    clears err_count (wins over increment)
//   err_count  saturating count of accepted invalid codes

module decoder_2to4_stream
  import decoder_pkg::*;
#(
  parameter int SEL_W     = DEC_SEL_W,
  parameter int ERR_CNT_W = DEC_ERR_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    invalid_in,
  input  logic [SEL_W-1:0]        sel_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<SEL_W)-1:0]   data_out,
  output logic                    err_out,
  input  logic                    err_clr,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int OUT_W = 1 << SEL_W;

  logic [OUT_W:0]          dec_word;
  logic                    dec_err;
  logic                    accept;
  logic                    fifo_push_valid;
  logic [ERR_CNT_W-1:0]    err_count_q;
  logic [ERR_CNT_W-1:0]    err_count_d;

  // The package helper covers the default width; other widths decode inline.
  generate
    if (SEL_W == DEC_SEL_W) begin : g_pkg_decode
      assign dec_word = dec_decode(invalid_in, sel_in);
    end else begin : g_inline_decode
      assign dec_word = {invalid_in, (invalid_in ? {OUT_W{1'b0}} : (OUT_W'(1) << sel_in))};
    end
  endgenerate

  assign dec_err = dec_word[OUT_W];
  assign accept  = in_valid && in_ready;

`ifdef DECODER_DROP_INVALID_EN
  logic [OUT_W-1:0] head_data;

  assign fifo_push_valid = in_valid && !dec_err;

  dec_fifo2 #(
    .DATA_W (OUT_W)
  ) u_fifo (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .push_valid_i (fifo_push_valid),
    .push_data_i  (dec_word[OUT_W-1:0]),
    .push_ready_o (in_ready),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head_data)
  );

  assign data_out = head_data;
  assign err_out  = 1'b0;
`else
  logic [OUT_W:0] head_word;

  assign fifo_push_valid = in_valid;

  dec_fifo2 #(
    .DATA_W (OUT_W + 1)
  ) u_fifo (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .push_valid_i (fifo_push_valid),
    .push_data_i  (dec_word),
    .push_ready_o (in_ready),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head_word)
  );

  assign data_out = head_word[OUT_W-1:0];
  assign err_out  = head_word[OUT_W];
`endif

  // Clear wins; an invalid word accepted in the clearing cycle still counts once.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = (accept && dec_err) ? ERR_CNT_W'(1) : '0;
    end else if (accept && dec_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_decoder_2to4_stream.sv
// tb/tb_decoder_2to4_stream.sv - directed self-checking bench for decoder_2to4_stream

module tb_decoder_2to4_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       invalid_in;
  logic [1:0] sel_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic       err_out;
  logic       err_clr;
  logic [7:0] err_count;

  int total_checks;
  int passed_checks;
  int failed_checks;

  decoder_2to4_stream #(
    .SEL_W     (2),
    .ERR_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .invalid_in (invalid_in),
    .sel_in     (sel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_out    (err_out),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [3:0] onehot_tbl [4];

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    onehot_tbl[0] = 4'b0001;
    onehot_tbl[1] = 4'b0010;
    onehot_tbl[2] = 4'b0100;
    onehot_tbl[3] = 4'b1000;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    invalid_in = 1'b0;
    sel_in     = 2'd0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err_out", err_out, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single word, sel=2
    in_valid  = 1'b1;
    sel_in    = 2'd2;
    out_ready = 1'b1;
    tick();
    chk("single_out_valid", out_valid, 1);
    chk("single_data_out", data_out, 4'b0100);
    chk("single_err_out", err_out, 0);
    chk("single_err_count", err_count, 0);
    in_valid = 1'b0;
    tick();
    chk("single_drained", out_valid, 0);

    // Back-to-back stream 0..3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sel_in   = 2'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), data_out, onehot_tbl[i]);
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_ready_%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", out_valid, 0);

    // Backpressure: fill with sel 3 then sel 1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel_in    = 2'd3;
    tick();
    chk("bp_first_data", data_out, 4'b1000);
    chk("bp_first_ready", in_ready, 1);
    sel_in = 2'd1;
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_data", data_out, 4'b1000);
    in_valid = 1'b0;
    sel_in   = 2'bxx;
    tick();
    chk("bp_hold_data", data_out, 4'b1000);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_head", data_out, 4'b1000);
    tick();
    chk("bp_second_data", data_out, 4'b0010);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_drained", out_valid, 0);

    // Invalid word: forwarded or dropped depending on build
    sel_in     = 2'd0;
    in_valid   = 1'b1;
    invalid_in = 1'b1;
    tick();
`ifdef DECODER_DROP_INVALID_EN
    chk("drop_out_valid", out_valid, 0);
    chk("drop_err_count", err_count, 1);
`else
    chk("fwd_out_valid", out_valid, 1);
    chk("fwd_data_out", data_out, 4'b0000);
    chk("fwd_err_out", err_out, 1);
    chk("fwd_err_count", err_count, 1);
`endif
    in_valid = 1'b0;
    err_clr  = 1'b1;
    tick();
    chk("clr_alone", err_count, 0);
    err_clr = 1'b0;

    // Saturation with 300 invalid words
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) chk("sat_count_10", err_count, 10);
      if (i == 254) chk("sat_count_255", err_count, 255);
    end
    chk("sat_hold", err_count, 255);
    chk("sat_ready", in_ready, 1);
    err_clr = 1'b1;
    tick();
    chk("clr_with_inc", err_count, 1);
    err_clr    = 1'b0;
    in_valid   = 1'b0;
    invalid_in = 1'b0;
    tick();
    chk("sat_drained", out_valid, 0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel_in    = 2'd0;
    tick();
    sel_in = 2'd1;
    tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_head", data_out, 4'b0001);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_err_count", err_count, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_release_ready", in_ready, 1);
    chk("midrst_no_residue", out_valid, 0);
    out_ready = 1'b1;
    tick();
    chk("midrst_still_empty", out_valid, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/decoder_2to4_stream.md
Name: decoder_2to4_stream

Overview:
- Inverse of the team's 4-to-2 encoders: accepts encoded words {invalid, sel} and regenerates one-hot data words.
- Valid/ready on both sides.
- 2-entry output buffer gives full throughput with a registered-only in_ready.
- Saturating error counter tallies accepted invalid codes; sits downstream of any encoder_4to2 / encoder_4to2_priority output.

Parameters:
- SEL_W, 2, width of encoded select; OUT_W = 2**SEL_W (derived localparam, 4 by default).
- ERR_CNT_W, 8, width of saturating invalid-code counter.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  encoded word present
- in_ready  output  1  block can accept a word this cycle
- invalid_in  input  1  encoder's invalid_data flag
- sel_in  input  SEL_W  encoder's y_out code
- out_valid  output  1  decoded word present
- out_ready  input  1  consumer accepts word
- data_out  output  OUT_W  one-hot decoded word (all-zero for invalid)
- err_out  output  1  word at head came from an invalid code
- err_clr  input  1  clears err_count
- err_count  output  ERR_CNT_W  number of accepted invalid codes, saturating

Behaviour:
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Decode at push: invalid_in=1 -> data 0, err 1; else data = 1 << sel_in, err 0.
- Buffer occupancy FSM with states EMPTY (0), ONE (1) and FULL (2):
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE (new word becomes head).
  - FULL: pop -> ONE; no push possible.
- in_ready = (state != FULL), decoded from state register only; never combinational on out_ready.
- out_valid = (state != EMPTY). data_out/err_out driven from the head entry register. Both are stable while out_valid && !out_ready.
- Latency: a word accepted at edge k is presented on out_valid/data_out from edge k (visible in cycle k+1) when the buffer was empty.
- Ordering is strictly FIFO. No word is lost or duplicated.
- err_count increments by 1 on every accepted word with invalid_in=1 and saturates at 2**ERR_CNT_W-1.
  - err_clr has priority: clear and increment in the same cycle -> 1.
  - err_clr alone -> 0.
- Reset (rst_n low at an edge):
  - state=EMPTY, data_out=0, err_out=0, err_count=0, both buffer entries cleared.
  - in_ready is forced 0 while rst_n is low; it is 1 from the first cycle after release.
- Reset mid-transfer: buffered words are discarded, with no partial output.
- X on sel_in is ignored when in_valid=0.

Optional Feature:
- DECODER_DROP_INVALID_EN.
- Defined: invalid words are accepted (handshake completes, err_count increments) but never pushed. Occupancy is unchanged, and err_out is tied 0.
- Undefined: invalid words are forwarded as data_out=0 with err_out=1 (default behaviour above).

Decomposition:
- Package decoder_pkg:
  - occupancy state typedef {EMPTY, ONE, FULL} (2-bit encoding 0/1/2);
  - default SEL_W and ERR_CNT_W constants;
  - a decode function (invalid, sel) -> {err, onehot}.
- One natural sub-module: dec_fifo2, a 2-entry buffer holding {err, data} with the occupancy FSM and in_ready/out_valid. The top level adds decode, the drop option and the error counter.

Test Plan:
- Reset, then in_valid=1, invalid_in=0, sel_in=2, out_ready=1 -> next cycle out_valid=1, data_out=4'b0100, err_out=0; err_count=0.
- Stream sel 0,1,2,3 back-to-back with out_ready=1 -> data_out 0001, 0010, 0100, 1000 on consecutive cycles; in_ready stays 1.
- out_ready=0, push sel 3 then sel 1 -> in_ready=0 after the second push. data_out holds 1000; raising out_ready yields 1000 then 0010.
- Push 300 invalid words -> err_count=255 (saturated). Then err_clr with a simultaneous invalid push -> err_count=1.
- Drop test:
  - without DECODER_DROP_INVALID_EN, push invalid -> data_out=0000, err_out=1;
  - with the macro defined -> out_valid stays 0 and err_count=1.
- Buffer FULL, assert rst_n=0 for one edge -> out_valid=0, data_out=0, in_ready=0 during reset, in_ready=1 after release.
